// File: rtl/mux_pipe_rr_pkg.sv
// Shared constants for the N-channel merge pipe: arbitration mode encodings and channel-index width.
package mux_pipe_rr_pkg;

  localparam int unsigned MUX_PIPE_MODE_RR   = 0;
  localparam int unsigned MUX_PIPE_MODE_PRIO = 1;

  // Channel index width; a single channel still needs one bit on the output port.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_pipe_rr_fifo.sv
// Per-channel FIFO: registered storage with wrap-bit pointers, head visible one cycle after enqueue.
module mux_pipe_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq_ena,
  input  logic [WIDTH-1:0] enq_v,
  output logic             enq_rdy,
  input  logic             deq_ena,
  output logic             deq_rdy,
  output logic [WIDTH-1:0] first
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             do_enq;
  logic             do_deq;

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign enq_rdy = !full;
  assign deq_rdy = !empty;
  assign do_enq  = enq_ena && !full;
  assign do_deq  = deq_ena && !empty;
  assign first   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_enq) mem[wr_ptr[AW-1:0]] <= enq_v;
  end

endmodule

// File: rtl/mux_pipe_rr.sv
// N-channel merge pipe: one FIFO per input channel, drained by a round-robin or fixed-priority arbiter.
module mux_pipe_rr
  import mux_pipe_rr_pkg::*;
#(
  parameter  int unsigned WIDTH = 128,
  parameter  int unsigned NCH   = 2,
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned MODE  = MUX_PIPE_MODE_RR,
  localparam int unsigned CHW   = ch_width(NCH)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [NCH-1:0]       in_enq__ENA,
  input  logic [NCH*WIDTH-1:0] in_enq_v,
  output logic [NCH-1:0]       in_enq__RDY,
  output logic                 out_enq__ENA,
  output logic [WIDTH-1:0]     out_enq_v,
  output logic [CHW-1:0]       out_enq_ch,
  input  logic                 out_enq__RDY
);

  logic [NCH-1:0]   req;
  logic [WIDTH-1:0] head [NCH];
  logic [CHW-1:0]   rr_ptr;
  logic [CHW-1:0]   shamt;
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic             found;
  logic [CHW-1:0]   pick;
  logic [CHW:0]     sum;
  logic [CHW-1:0]   grant;
  logic             any;

  for (genvar g = 0; g < NCH; g++) begin : g_fifo
    mux_pipe_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .CLK    (CLK),
      .nRST   (nRST),
      .enq_ena(in_enq__ENA[g]),
      .enq_v  (in_enq_v[g*WIDTH +: WIDTH]),
      .enq_rdy(in_enq__RDY[g]),
      .deq_ena(out_enq__ENA && (grant == CHW'(g))),
      .deq_rdy(req[g]),
      .first  (head[g])
    );
  end

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    shamt = (MODE == MUX_PIPE_MODE_RR) ? rr_ptr : '0;
    dbl   = {req, req};
    rot   = NCH'(dbl >> shamt);
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        pick  = CHW'(i);
      end
    end
    sum = {1'b0, pick} + {1'b0, shamt};
    if (sum >= (CHW+1)'(NCH)) sum = sum - (CHW+1)'(NCH);
    grant = sum[CHW-1:0];
  end

  assign any          = |req;
  assign out_enq__ENA = any && out_enq__RDY;
  assign out_enq_v    = any ? head[grant] : '0;
  assign out_enq_ch   = any ? grant : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr <= '0;
    end else if (out_enq__ENA && (MODE == MUX_PIPE_MODE_RR)) begin
      rr_ptr <= (grant == CHW'(NCH-1)) ? '0 : grant + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_pipe_rr.sv
// Scoreboard bench for mux_pipe_rr: a round-robin instance and a fixed-priority instance.
module tb_mux_pipe_rr;

  localparam int unsigned W = 16;
  localparam int unsigned N = 4;
  localparam int unsigned D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [N-1:0]   a_in_ena, a_in_rdy, b_in_ena, b_in_rdy;
  logic [N*W-1:0] a_in_v, b_in_v;
  logic           a_out_ena, a_out_rdy, b_out_ena, b_out_rdy;
  logic [W-1:0]   a_out_v, b_out_v;
  logic [1:0]     a_out_ch, b_out_ch;

  mux_pipe_rr #(.WIDTH(W), .NCH(N), .DEPTH(D), .MODE(0)) dut_a (
    .CLK(clk), .nRST(rst_n),
    .in_enq__ENA(a_in_ena), .in_enq_v(a_in_v), .in_enq__RDY(a_in_rdy),
    .out_enq__ENA(a_out_ena), .out_enq_v(a_out_v), .out_enq_ch(a_out_ch),
    .out_enq__RDY(a_out_rdy)
  );

  mux_pipe_rr #(.WIDTH(W), .NCH(N), .DEPTH(D), .MODE(1)) dut_b (
    .CLK(clk), .nRST(rst_n),
    .in_enq__ENA(b_in_ena), .in_enq_v(b_in_v), .in_enq__RDY(b_in_rdy),
    .out_enq__ENA(b_out_ena), .out_enq_v(b_out_v), .out_enq_ch(b_out_ch),
    .out_enq__RDY(b_out_rdy)
  );

  typedef struct packed {
    logic [1:0]   ch;
    logic [W-1:0] v;
  } item_t;

  item_t       sb_a[$];
  item_t       sb_b[$];
  int unsigned log_a[$];
  int unsigned log_b[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned out_cnt_a = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_a(input int ch, input logic [W-1:0] v);
    item_t it;
    it.ch = 2'(ch);
    it.v  = v;
    a_in_ena[ch] = 1'b1;
    a_in_v[ch*W +: W] = v;
    sb_a.push_back(it);
  endtask

  task automatic enq_b(input int ch, input logic [W-1:0] v);
    item_t it;
    it.ch = 2'(ch);
    it.v  = v;
    b_in_ena[ch] = 1'b1;
    b_in_v[ch*W +: W] = v;
    sb_b.push_back(it);
  endtask

  // Oldest outstanding entry of the observed channel must match: keeps per-channel order, flags loss/dup.
  task automatic sb_check(input bit use_b, input logic [1:0] ch, input logic [W-1:0] v);
    int           idx;
    logic [W-1:0] exp;
    idx = -1;
    exp = '0;
    if (!use_b) begin
      foreach (sb_a[i]) if (idx < 0 && sb_a[i].ch == ch) idx = i;
      if (idx >= 0) begin
        exp = sb_a[idx].v;
        sb_a.delete(idx);
      end
    end else begin
      foreach (sb_b[i]) if (idx < 0 && sb_b[i].ch == ch) idx = i;
      if (idx >= 0) begin
        exp = sb_b[idx].v;
        sb_b.delete(idx);
      end
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL %s: unexpected item ch=%0d v=%0h, expected no output", use_b ? "sb_b" : "sb_a", ch, v);
    end else if (v !== exp) begin
      errors++;
      $display("FAIL %s: ch=%0d got %0h expected %0h", use_b ? "sb_b" : "sb_a", ch, v, exp);
    end
  endtask

  task automatic monitor();
    logic         pend;
    logic         enq_prev;
    logic [W-1:0] pv;
    logic [1:0]   pc;
    pend     = 1'b0;
    enq_prev = 1'b0;
    pv       = '0;
    pc       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && pend && !enq_prev) begin
        check("stall_v", 64'(a_out_v), 64'(pv));
        check("stall_ch", 64'(a_out_ch), 64'(pc));
      end
      pend     = rst_n && !a_out_rdy && (a_out_v != '0);
      enq_prev = |a_in_ena;
      pv       = a_out_v;
      pc       = a_out_ch;
      if (rst_n && a_out_ena) begin
        out_cnt_a++;
        log_a.push_back(int'(a_out_ch));
        sb_check(1'b0, a_out_ch, a_out_v);
      end
      if (rst_n && b_out_ena) begin
        log_b.push_back(int'(b_out_ch));
        sb_check(1'b1, b_out_ch, b_out_v);
      end
    end
  endtask

  task automatic stimulus();
    int unsigned base;
    int unsigned n0;
    int unsigned issued;
    int unsigned cyc;

    repeat (2) step();
    check("rst_a_ena", 64'(a_out_ena), 0);
    check("rst_a_rdy", 64'(a_in_rdy), 64'hF);
    check("rst_a_v", 64'(a_out_v), 0);
    check("rst_a_ch", 64'(a_out_ch), 0);
    check("rst_b_rdy", 64'(b_in_rdy), 64'hF);
    rst_n = 1'b1;
    step();

    // two entries queued, then reset mid-stream
    enq_a(0, 16'h0001);
    enq_a(2, 16'h0002);
    step();
    a_in_ena = '0;
    step();
    check("pre_rst_v", 64'(a_out_v), 64'h0001);
    rst_n = 1'b0;
    sb_a.delete();
    step();
    check("mid_rst_rdy", 64'(a_in_rdy), 64'hF);
    check("mid_rst_ena", 64'(a_out_ena), 0);
    check("mid_rst_v", 64'(a_out_v), 0);
    base = out_cnt_a;
    a_out_rdy = 1'b1;
    rst_n = 1'b1;
    repeat (4) step();
    check("rst_discard", 64'(out_cnt_a - base), 0);

    // latency: no bypass, visible one cycle later
    enq_a(1, 16'h00A5);
    check("lat_t_ena", 64'(a_out_ena), 0);
    step();
    a_in_ena = '0;
    check("lat_ena", 64'(a_out_ena), 1);
    check("lat_v", 64'(a_out_v), 64'h00A5);
    check("lat_ch", 64'(a_out_ch), 1);
    step();
    check("lat_done", 64'(a_out_ena), 0);

    // full
    a_out_rdy = 1'b0;
    check("full_rdy0", 64'(a_in_rdy[0]), 1);
    enq_a(0, 16'h0011);
    step();
    check("full_rdy1", 64'(a_in_rdy[0]), 1);
    enq_a(0, 16'h0012);
    step();
    a_in_ena = '0;
    check("full_rdy2", 64'(a_in_rdy[0]), 0);
    step();
    check("full_hold", 64'(a_in_rdy[0]), 0);
    check("full_head", 64'(a_out_v), 64'h0011);
    a_out_rdy = 1'b1;
    step();
    check("full_pop_rdy", 64'(a_in_rdy[0]), 1);
    check("full_second", 64'(a_out_v), 64'h0012);
    step();
    check("full_empty", 64'(a_out_ena), 0);

    // round-robin from a fresh pointer
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_out_rdy = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < int'(N); c++) enq_a(c, 16'(16'h0100 + c*16 + k));
      step();
    end
    a_in_ena = '0;
    check("rr_full", 64'(a_in_rdy), 0);
    log_a.delete();
    a_out_rdy = 1'b1;
    repeat (9) step();
    check("rr_count", 64'(log_a.size()), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("rr_seq%0d", i), (i < log_a.size()) ? 64'(log_a[i]) : 64'd99, 64'(i % 4));

    // fixed priority: ch0 kept backlogged against ch2
    b_out_rdy = 1'b0;
    enq_b(0, 16'h0201);
    enq_b(2, 16'h0221);
    step();
    enq_b(0, 16'h0202);
    enq_b(2, 16'h0222);
    step();
    b_in_ena = '0;
    log_b.delete();
    n0 = 2;
    b_out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (b_in_rdy[0]) begin
        enq_b(0, 16'(16'h0201 + n0));
        n0++;
      end
      step();
      b_in_ena = '0;
    end
    repeat (6) step();
    check("prio_count", 64'(log_b.size()), 64'(n0 + 2));
    for (int i = 0; i < int'(n0) + 2; i++)
      check($sformatf("prio_seq%0d", i), (i < log_b.size()) ? 64'(log_b[i]) : 64'd99,
            (i < int'(n0)) ? 64'd0 : 64'd2);

    // random back-pressure soak
    issued = 0;
    cyc = 0;
    while ((issued < 10000 || sb_a.size() != 0) && cyc < 60000) begin
      a_in_ena = '0;
      a_out_rdy = (issued < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 0; c < int'(N); c++) begin
        if (a_in_rdy[c] && ($urandom_range(0, 1) == 1) && issued < 10000) begin
          issued++;
          enq_a(c, 16'(issued));
        end
      end
      step();
      cyc++;
    end
    a_in_ena = '0;
    repeat (3) step();
    check("soak_timeout", 64'(cyc < 60000), 1);
    check("soak_issued", 64'(issued), 10000);
    check("soak_drained", 64'(sb_a.size()), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    a_in_ena  = '0;
    a_in_v    = '0;
    a_out_rdy = 1'b0;
    b_in_ena  = '0;
    b_in_v    = '0;
    b_out_rdy = 1'b0;
    fork
      monitor();
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
